// File: rtl/unwrap_shifter.sv
// Undoes the kernel's word-line rotation and reports the one-hot position.
// Two-entry FIFO (output register + skid) with a registered ready.
module unwrap_shifter #(
    parameter int WIDTH = 9
) (
    input  logic             Phi1,
    input  logic             Reset_s1,
    input  logic             in_valid_s1,
    output logic             in_ready_s1,
    input  logic [2:0]       shiftcontrol_s1,
    input  logic [WIDTH-1:0] wrapped_s1,
    output logic             out_valid_s1,
    input  logic             out_ready_s1,
    output logic [WIDTH-1:0] unwrapped_s1,
    output logic [3:0]       index_s1,
    output logic             ctrl_err_s1,
    output logic             data_err_s1,
    output logic             seq_err_s1
);

    // Entry layout: {unwrapped, index, ctrl_err, data_err}
    localparam int EW = WIDTH + 6;
    localparam logic [EW-1:0] RESET_ENTRY = {{WIDTH{1'b0}}, 4'hF, 1'b0, 1'b0};

    logic [1:0]       occ_q, occ_d;
    logic [EW-1:0]    head_q, head_d;
    logic [EW-1:0]    skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [2:0]       exp_q, exp_d;
    logic             seq_err_q, seq_err_d;

    logic             ctrl_ok;
    logic [WIDTH-1:0] rot;
    logic [3:0]       ones;
    logic [3:0]       pos;
    logic             data_ok;
    logic [EW-1:0]    new_entry;
    logic             accept;
    logic             deliver;

    always_comb begin
        ctrl_ok = (shiftcontrol_s1 == 3'b100) || (shiftcontrol_s1 == 3'b010) ||
                  (shiftcontrol_s1 == 3'b001);
        case (shiftcontrol_s1)
            3'b010:  rot = {wrapped_s1[WIDTH-2:0], wrapped_s1[WIDTH-1]};
            3'b001:  rot = {wrapped_s1[WIDTH-3:0], wrapped_s1[WIDTH-1:WIDTH-2]};
            default: rot = wrapped_s1;
        endcase
        ones = 4'd0;
        pos  = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rot[i]) begin
                ones = ones + 4'd1;
                pos  = 4'(i);
            end
        end
        data_ok   = (ones == 4'd1);
        new_entry = {rot, data_ok ? pos : 4'hF, ~ctrl_ok, ~data_ok};
    end

    always_comb begin
        accept     = in_valid_s1 && in_ready_q;
        deliver    = (occ_q != 2'd0) && out_ready_s1;
        occ_d      = occ_q;
        head_d     = head_q;
        skid_d     = skid_q;
        exp_d      = exp_q;
        seq_err_d  = seq_err_q;
        case (occ_q)
            2'd0: begin
                if (accept) begin
                    head_d = new_entry;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (accept && deliver) begin
                    head_d = new_entry;
                end else if (accept) begin
                    skid_d = new_entry;
                    occ_d  = 2'd2;
                end else if (deliver) begin
                    occ_d  = 2'd0;
                end
            end
            default: begin
                // Ready is low whenever full, so only a drain can happen here.
                if (deliver) begin
                    head_d = skid_q;
                    occ_d  = 2'd1;
                end
            end
        endcase
        in_ready_d = (occ_d < 2'd2);
        if (accept && ctrl_ok) begin
            exp_d = {shiftcontrol_s1[1:0], shiftcontrol_s1[2]};
            if (shiftcontrol_s1 != exp_q) seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge Phi1) begin
        if (Reset_s1) begin
            occ_q      <= 2'd0;
            head_q     <= RESET_ENTRY;
            skid_q     <= RESET_ENTRY;
            in_ready_q <= 1'b0;
            exp_q      <= 3'b001;
            seq_err_q  <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            exp_q      <= exp_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign in_ready_s1  = in_ready_q;
    assign out_valid_s1 = (occ_q != 2'd0);
    assign unwrapped_s1 = head_q[EW-1:6];
    assign index_s1     = head_q[5:2];
    assign ctrl_err_s1  = head_q[1];
    assign data_err_s1  = head_q[0];
    assign seq_err_s1   = seq_err_q;

endmodule

// File: tb/tb_unwrap_shifter.sv
// Bench for unwrap_shifter: queue-based reference model checked every cycle,
// plus directed beats with hand-computed expectations.
module tb_unwrap_shifter;

    logic       Phi1 = 1'b0;
    logic       Reset_s1 = 1'b1;
    logic       in_valid_s1 = 1'b0;
    logic       in_ready_s1;
    logic [2:0] shiftcontrol_s1 = 3'b000;
    logic [8:0] wrapped_s1 = 9'd0;
    logic       out_valid_s1;
    logic       out_ready_s1 = 1'b1;
    logic [8:0] unwrapped_s1;
    logic [3:0] index_s1;
    logic       ctrl_err_s1, data_err_s1, seq_err_s1;

    unwrap_shifter #(.WIDTH(9)) dut (
        .Phi1(Phi1), .Reset_s1(Reset_s1),
        .in_valid_s1(in_valid_s1), .in_ready_s1(in_ready_s1),
        .shiftcontrol_s1(shiftcontrol_s1), .wrapped_s1(wrapped_s1),
        .out_valid_s1(out_valid_s1), .out_ready_s1(out_ready_s1),
        .unwrapped_s1(unwrapped_s1), .index_s1(index_s1),
        .ctrl_err_s1(ctrl_err_s1), .data_err_s1(data_err_s1),
        .seq_err_s1(seq_err_s1)
    );

    always #5 Phi1 = ~Phi1;

    typedef struct packed {
        logic [8:0] u;
        logic [3:0] idx;
        logic       c;
        logic       d;
    } beat_t;

    int    n_checks = 0;
    int    n_pass = 0;
    bit    cmp_en = 1'b0;
    beat_t mq[$];
    bit    m_ready = 1'b0;
    bit    m_seq = 1'b0;
    logic [2:0] m_exp = 3'b001;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic beat_t model_beat(input logic [2:0] c, input logic [8:0] w);
        beat_t b;
        int s;
        int ones;
        b = '0;
        s = (c == 3'b010) ? 1 : (c == 3'b001) ? 2 : 0;
        b.c = !(c == 3'b100 || c == 3'b010 || c == 3'b001);
        for (int i = 0; i < 9; i++) b.u[i] = w[(i - s + 9) % 9];
        ones = 0;
        for (int i = 0; i < 9; i++) if (b.u[i]) ones++;
        b.d = (ones != 1);
        b.idx = 4'hF;
        if (!b.d) for (int i = 0; i < 9; i++) if (b.u[i]) b.idx = 4'(i);
        return b;
    endfunction

    // Reference model: advances on each rising edge from the handshake rules.
    always @(posedge Phi1) begin
        if (Reset_s1) begin
            mq.delete();
            m_ready = 1'b0;
            m_seq = 1'b0;
            m_exp = 3'b001;
        end else begin
            bit acc, dlv;
            acc = in_valid_s1 && m_ready;
            dlv = (mq.size() > 0) && out_ready_s1;
            if (dlv) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(model_beat(shiftcontrol_s1, wrapped_s1));
                if (shiftcontrol_s1 == 3'b001 || shiftcontrol_s1 == 3'b010 ||
                    shiftcontrol_s1 == 3'b100) begin
                    if (shiftcontrol_s1 != m_exp) m_seq = 1'b1;
                    m_exp = (shiftcontrol_s1 == 3'b001) ? 3'b010 :
                            (shiftcontrol_s1 == 3'b010) ? 3'b100 : 3'b001;
                end
            end
            m_ready = (mq.size() < 2);
        end
    end

    always @(negedge Phi1) begin
        if (cmp_en) begin
            chk("out_valid", 16'(out_valid_s1), 16'(mq.size() > 0));
            chk("in_ready", 16'(in_ready_s1), 16'(m_ready));
            chk("seq_err", 16'(seq_err_s1), 16'(m_seq));
            if (mq.size() > 0) begin
                chk("unwrapped", 16'(unwrapped_s1), 16'(mq[0].u));
                chk("index", 16'(index_s1), 16'(mq[0].idx));
                chk("ctrl_err", 16'(ctrl_err_s1), 16'(mq[0].c));
                chk("data_err", 16'(data_err_s1), 16'(mq[0].d));
            end
        end
    end

    task automatic step();
        @(posedge Phi1);
        @(negedge Phi1);
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [8:0] w);
        in_valid_s1 = v;
        shiftcontrol_s1 = c;
        wrapped_s1 = w;
    endtask

    task automatic do_reset();
        Reset_s1 = 1'b1;
        drive(1'b0, 3'b000, 9'd0);
        step();
        step();
        Reset_s1 = 1'b0;
        step();
    endtask

    logic [2:0] ctab [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b010, 3'b111, 3'b100};
    logic [8:0] wtab [8] = '{9'h100, 9'h001, 9'h040, 9'h003, 9'h010, 9'h080, 9'h020, 9'h000};
    logic [7:0] rdy_pat = 8'b1011_0110;

    initial begin
        // Reset values while reset is held
        step();
        cmp_en = 1'b1;
        step();
        chk("rst out_valid", 16'(out_valid_s1), 16'd0);
        chk("rst in_ready", 16'(in_ready_s1), 16'd0);
        chk("rst unwrapped", 16'(unwrapped_s1), 16'd0);
        chk("rst index", 16'(index_s1), 16'hF);
        chk("rst flags", 16'({ctrl_err_s1, data_err_s1, seq_err_s1}), 16'd0);
        Reset_s1 = 1'b0;
        step();
        chk("ready after rst", 16'(in_ready_s1), 16'd1);

        // Kernel ring sequence, one beat per cycle
        drive(1'b1, 3'b001, 9'b000000010); step();
        chk("seq1 u", 16'(unwrapped_s1), 16'(9'b000001000));
        chk("seq1 idx", 16'(index_s1), 16'd3);
        drive(1'b1, 3'b010, 9'b000000100); step();
        chk("seq2 u", 16'(unwrapped_s1), 16'(9'b000001000));
        drive(1'b1, 3'b100, 9'b000001000); step();
        chk("seq3 u", 16'(unwrapped_s1), 16'(9'b000001000));
        chk("seq3 errs", 16'({ctrl_err_s1, data_err_s1, seq_err_s1}), 16'd0);

        // Wrap-around
        drive(1'b1, 3'b001, 9'b010000000); step();
        chk("wrap2 u", 16'(unwrapped_s1), 16'(9'b000000001));
        chk("wrap2 idx", 16'(index_s1), 16'd0);
        drive(1'b1, 3'b010, 9'b100000000); step();
        chk("wrap1 u", 16'(unwrapped_s1), 16'(9'b000000001));

        // Bad control and multi-hot data
        drive(1'b1, 3'b011, 9'h0A5); step();
        chk("err u", 16'(unwrapped_s1), 16'h0A5);
        chk("err flags", 16'({ctrl_err_s1, data_err_s1}), 16'b11);
        chk("err idx", 16'(index_s1), 16'hF);
        chk("err seq", 16'(seq_err_s1), 16'd0);
        drive(1'b0, 3'b000, 9'd0); step();
        chk("idle valid", 16'(out_valid_s1), 16'd0);

        // Sequence violation is sticky until reset
        do_reset();
        drive(1'b1, 3'b100, 9'h001); step();
        chk("viol set", 16'(seq_err_s1), 16'd1);
        drive(1'b1, 3'b001, 9'h001); step();
        drive(1'b1, 3'b010, 9'h001); step();
        drive(1'b0, 3'b000, 9'd0); step();
        chk("viol sticky", 16'(seq_err_s1), 16'd1);
        do_reset();
        chk("viol cleared", 16'(seq_err_s1), 16'd0);

        // Backpressure: two accepted, third refused, drained in order
        out_ready_s1 = 1'b0;
        drive(1'b1, 3'b001, 9'b000000001); step();
        chk("bp ready1", 16'(in_ready_s1), 16'd1);
        drive(1'b1, 3'b010, 9'b000000100); step();
        chk("bp ready2", 16'(in_ready_s1), 16'd0);
        drive(1'b1, 3'b100, 9'b000010000); step();
        chk("bp held u", 16'(unwrapped_s1), 16'(9'b000000100));
        chk("bp held idx", 16'(index_s1), 16'd2);
        chk("bp full", 16'(in_ready_s1), 16'd0);
        drive(1'b0, 3'b000, 9'd0);
        out_ready_s1 = 1'b1;
        step();
        chk("bp drain2", 16'(unwrapped_s1), 16'(9'b000001000));
        step();
        chk("bp empty", 16'(out_valid_s1), 16'd0);

        // Reset while holding two beats
        out_ready_s1 = 1'b0;
        drive(1'b1, 3'b100, 9'h001); step();
        drive(1'b1, 3'b001, 9'h001); step();
        Reset_s1 = 1'b1;
        out_ready_s1 = 1'b1;
        drive(1'b1, 3'b010, 9'h002); step();
        chk("midrst valid", 16'(out_valid_s1), 16'd0);
        Reset_s1 = 1'b0;
        drive(1'b0, 3'b000, 9'd0); step();
        step();
        chk("midrst stays", 16'(out_valid_s1), 16'd0);

        // Mixed vectors with irregular downstream readiness
        for (int i = 0; i < 24; i++) begin
            drive((i % 3) != 2, ctab[i % 8], wtab[(i * 3) % 8]);
            out_ready_s1 = rdy_pat[i % 8];
            step();
        end
        drive(1'b0, 3'b000, 9'd0);
        out_ready_s1 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("final empty", 16'(out_valid_s1), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/unwrap_shifter.md
UNWRAP_SHIFTER -- requirements
Module: unwrap_shifter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 9, word-line state width; only 9 is supported.
REQ-002 The port Phi1 SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port Reset_s1 SHALL be an input, 1 bit wide: the reset, synchronous and active-high.
REQ-004 The port in_valid_s1 SHALL be an input, 1 bit wide: the upstream beat is valid.
REQ-005 The port in_ready_s1 SHALL be an output, 1 bit wide: the block can accept a beat.
REQ-006 The port shiftcontrol_s1 SHALL be an input, 3 bits wide: one-hot rotate code (100 none, 010 right-1, 001 right-2).
REQ-007 The port wrapped_s1 SHALL be an input, 9 bits wide: the rotated word-line pattern.
REQ-008 The port out_valid_s1 SHALL be an output, 1 bit wide: the output beat is valid.
REQ-009 The port out_ready_s1 SHALL be an input, 1 bit wide: downstream accepts the output beat.
REQ-010 The port unwrapped_s1 SHALL be an output, 9 bits wide: the recovered original pattern.
REQ-011 The port index_s1 SHALL be an output, 4 bits wide: the binary position of the single set bit in unwrapped_s1.
REQ-012 The port ctrl_err_s1 SHALL be an output, 1 bit wide: per-beat flag, shiftcontrol_s1 was not one-hot.
REQ-013 The port data_err_s1 SHALL be an output, 1 bit wide: per-beat flag, unwrapped_s1 was not one-hot.
REQ-014 The port seq_err_s1 SHALL be an output, 1 bit wide: sticky flag, control-sequence violation.

Function
REQ-015 A beat SHALL be accepted in any cycle in which in_valid_s1 and in_ready_s1 are both 1.
REQ-016 A beat SHALL be delivered in any cycle in which out_valid_s1 and out_ready_s1 are both 1.
REQ-017 Control 100 SHALL give unwrapped = wrapped.
REQ-018 Control 010 SHALL rotate left by 1: unwrapped[8:1] = wrapped[7:0] and unwrapped[0] = wrapped[8].
REQ-019 Control 001 SHALL rotate left by 2: unwrapped[8:2] = wrapped[6:0] and unwrapped[1:0] = wrapped[8:7].
REQ-020 Any other control value (000 or multi-hot) SHALL pass the data through unchanged and set that beat's ctrl_err_s1 to 1.
REQ-021 index_s1 SHALL be 0..8 for a one-hot result, and 4'hF with data_err_s1=1 for a zero or multi-hot result.
REQ-022 Buffering SHALL be a 2-entry FIFO (output register plus skid), with beat data, index and per-beat flags stored together.
REQ-023 in_ready_s1 SHALL be registered: 1 when the occupancy after the current cycle is less than 2, with no combinational path from out_ready_s1.
REQ-024 Latency SHALL be 1 cycle: a beat accepted in cycle N into an empty buffer is presented with out_valid_s1=1 in cycle N+1.
REQ-025 Beats SHALL leave in acceptance order.
REQ-026 Output data SHALL be held stable while out_valid_s1=1 and out_ready_s1=0.
REQ-027 With a simultaneous accept and deliver, occupancy SHALL be unchanged and no beat lost or duplicated.
REQ-028 When full (occupancy 2), in_ready_s1 SHALL be 0; beats offered while full are not accepted and in_valid_s1 is ignored.
REQ-029 An expected-control register SHALL track the kernel ring sequence 001 -> 010 -> 100 -> 001.
REQ-030 On each accepted beat with one-hot control, expected SHALL become the received control rotated left by 1.
REQ-031 If that one-hot control differs from expected, seq_err_s1 SHALL be set to 1 and hold until reset.
REQ-032 A beat with non-one-hot control SHALL leave expected unchanged and SHALL NOT set seq_err_s1.

Reset
REQ-033 When Reset_s1=1 at a Phi1 edge, occupancy SHALL become 0 and out_valid_s1 SHALL be 0.
REQ-034 Reset SHALL set in_ready_s1=0 during the reset cycle and 1 from the first cycle after Reset_s1 deasserts.
REQ-035 Reset SHALL set unwrapped_s1=9'b0, index_s1=4'hF, all three error flags to 0, and expected control to 001.
REQ-036 Reset asserted mid-operation SHALL discard buffered beats and take priority over a simultaneous accept or deliver.

Verification
REQ-037 After reset, with out_ready_s1=1, the bench SHALL send (001, 9'b000000010), then (010, 9'b000000100), then (100, 9'b000001000); unwrapped_s1 SHALL be 9'b000001000, 000001000, 000001000 with index 3, one per cycle, and no errors.
REQ-038 The bench SHALL check wrap-around: control 001 with wrapped 9'b010000000 SHALL give unwrapped 9'b000000001 and index 0; control 010 with 9'b100000000 SHALL give 9'b000000001.
REQ-039 The bench SHALL check error flags: control 011 with wrapped 9'h0A5 SHALL give unwrapped 9'h0A5, ctrl_err=1, data_err=1 and index 4'hF; seq_err SHALL stay 0.
REQ-040 The bench SHALL check sequence violation: after reset, a first beat with control 100 SHALL set seq_err=1, which stays 1 through later correct beats until Reset_s1.
REQ-041 The bench SHALL check backpressure: holding out_ready_s1=0 and offering 3 beats SHALL accept exactly 2 with in_ready_s1=0 after the second; releasing out_ready_s1 SHALL drain both in order.
REQ-042 The bench SHALL check reset mid-operation: Reset_s1 pulsed while holding 2 beats SHALL give out_valid_s1=0 the next cycle, with no stale beat ever delivered.
